// File: rtl/iter_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/shift/add ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder behind a start/ready/valid handshake.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_MUL,
    K_DIV,
    K_REM
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, valid_q;

  logic [WIDTH-1:0] imm_res;
  logic             iter_op;
  kind_t            iter_kind;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fit;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  assign shamt = data2_i[SHW-1:0];

  // Decode of the operation presented at accept: immediate result or iterative kind.
  always_comb begin
    imm_res   = '0;
    iter_op   = 1'b0;
    iter_kind = K_MUL;
    case (ALUCtrl_i)
      OP_AND: imm_res = data1_i & data2_i;
      OP_XOR: imm_res = data1_i ^ data2_i;
      OP_SLL: imm_res = data1_i << shamt;
      OP_ADD: imm_res = data1_i + data2_i;
      OP_SUB: imm_res = data1_i - data2_i;
      OP_SRA: imm_res = $unsigned($signed(data1_i) >>> shamt);
      OP_MUL: begin
        iter_op   = 1'b1;
        iter_kind = K_MUL;
      end
      OP_DIVU: begin
        if (data2_i == '0) begin
          imm_res = '1;
        end else begin
          iter_op   = 1'b1;
          iter_kind = K_DIV;
        end
      end
      OP_REMU: begin
        if (data2_i == '0) begin
          imm_res = data1_i;
        end else begin
          iter_op   = 1'b1;
          iter_kind = K_REM;
        end
      end
      default: imm_res = '0;
    endcase
  end

  // One iteration step: a_q/b_q are multiplicand/multiplier for MUL, dividend-quotient/divisor for DIV/REM.
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    div_shift   = {rem_q, a_q[WIDTH-1]};
    div_diff    = div_shift - {1'b0, b_q};
    div_fit     = ~div_diff[WIDTH];
    div_rem_nxt = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nxt = {a_q[WIDTH-2:0], div_fit};
  end

  // Next-state and datapath update; kill beats both completion and a new start.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    data_d  = data_q;

    if (kill_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start_i) begin
            if (iter_op) begin
              state_d = S_BUSY;
              kind_d  = iter_kind;
              cnt_d   = '0;
              a_d     = data1_i;
              b_d     = data2_i;
              acc_d   = '0;
              rem_d   = '0;
            end else begin
              state_d = S_DONE;
              data_d  = imm_res;
            end
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q + SHW'(1);
          if (kind_q == K_MUL) begin
            acc_d = mul_acc_nxt;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else begin
            a_d   = div_quo_nxt;
            rem_d = div_rem_nxt;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            case (kind_q)
              K_MUL:   data_d = mul_acc_nxt;
              K_DIV:   data_d = div_quo_nxt;
              default: data_d = div_rem_nxt;
            endcase
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      kind_q  <= K_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      ready_q <= (state_d != S_BUSY);
      valid_q <= (state_d == S_DONE);
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
